fetch_sequencer: RTL and testbench

Instruction-fetch controller for the pipelined CPU. It owns the program counter and drives the address of the combinational instruction ROM. It registers the returned 9-bit instruction into the IF/ID stage and applies stall, redirect (branch/jump) and halt sequencing. It sits between the instruction ROM and the decode stage.

---
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller. Owns the PC, addresses the
// combinational instruction ROM and registers the fetched instruction into
// the IF/ID stage. Sequences stall, redirect (branch/jump) and halt.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'd1,
    parameter logic [4:0]  HALT_OPCODE = 5'b11010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] rom_pc,
    input  logic [8:0]  rom_instruction,
    output logic        if_valid,
    output logic [8:0]  if_instruction,
    output logic [15:0] if_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {RUN, HALTED} state_t;

    // Halt encoding doubles as the reset value of the IF/ID instruction.
    localparam logic [8:0] HALT_INSTR = {HALT_OPCODE, 4'h0};

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic        valid_n;
    logic [8:0]  instr_n;
    logic [15:0] ipc_n;
    logic [15:0] count_n;
    logic        is_halt;

    assign is_halt = (rom_instruction[8:4] == HALT_OPCODE);

    // rom_pc is the bare PC register: no combinational path from inputs.
    assign rom_pc = pc;
    assign halted = (state == HALTED);

    // State and datapath registers; reset restores everything at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_instruction <= HALT_INSTR;
            if_pc          <= 16'd0;
            fetch_count    <= 16'd0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            if_valid       <= valid_n;
            if_instruction <= instr_n;
            if_pc          <= ipc_n;
            fetch_count    <= count_n;
        end
    end

    // Next-state: redirect beats stall beats normal fetch; HALTED drains the
    // issued halt to a bubble once decode accepts it.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = if_valid;
        instr_n = if_instruction;
        ipc_n   = if_pc;
        count_n = fetch_count;
        if (redirect_valid) begin
            // Flushed slot becomes a bubble; old if_* contents are kept.
            state_n = RUN;
            pc_n    = redirect_pc;
            valid_n = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        instr_n = rom_instruction;
                        ipc_n   = pc;
                        valid_n = 1'b1;
                        count_n = fetch_count + 16'd1;
                        if (is_halt) begin
                            state_n = HALTED;
                        end else begin
                            pc_n = pc + 16'd1;
                        end
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        valid_n = 1'b0;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven directed check of fetch_sequencer against
// a behavioural ROM, plus hand-written reset sequences.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] rom_pc;
    logic [8:0]  rom_instruction;
    logic        if_valid;
    logic [8:0]  if_instruction;
    logic [15:0] if_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [8:0] rom [0:65535];

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        st;
        logic        rv;
        logic [15:0] rpc;
        logic        v;
        logic [8:0]  ins;
        logic [15:0] ipc;
        logic [15:0] rom_pc;
        logic        h;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    assign rom_instruction = rom[rom_pc];

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_pc         (rom_pc),
        .rom_instruction(rom_instruction),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    function automatic vec_t mk(logic st, logic rv, logic [15:0] rpc, logic v,
                                logic [8:0] ins, logic [15:0] ipc,
                                logic [15:0] rp, logic h, logic [15:0] cnt);
        vec_t t;
        t.st = st; t.rv = rv; t.rpc = rpc; t.v = v; t.ins = ins;
        t.ipc = ipc; t.rom_pc = rp; t.h = h; t.cnt = cnt;
        return t;
    endfunction

    // One edge with the given inputs, outputs sampled 1 time unit later.
    task automatic step(input logic rst, input logic st, input logic rv,
                        input logic [15:0] rpc);
        reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic v, input logic [8:0] ins,
                         input logic [15:0] ipc, input logic [15:0] rp,
                         input logic h, input logic [15:0] cnt);
        logic [58:0] act, exp;
        act = {if_valid, if_instruction, if_pc, rom_pc, halted, fetch_count};
        exp = {v, ins, ipc, rp, h, cnt};
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got v=%b ins=%h if_pc=%h rom_pc=%h halted=%b cnt=%0d, want v=%b ins=%h if_pc=%h rom_pc=%h halted=%b cnt=%0d",
                     name, if_valid, if_instruction, if_pc, rom_pc, halted, fetch_count,
                     v, ins, ipc, rp, h, cnt);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, 1'b0, 9'h1A0, 16'h0000, 16'h0001, 1'b0, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 9'h1A0;
        rom[1] = 9'h061; rom[2] = 9'h090; rom[3] = 9'h191;
        rom[4] = 9'h164; rom[5] = 9'h0E0;
        rom[16'hFFFF] = 9'h0F1; rom[0] = 9'h0F2;

        //             st rv rpc       v  ins     if_pc     rom_pc    h  cnt
        // straight line with a 3-cycle stall at if_pc=3, then halt at 6
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h061, 16'd1,    16'd2,    0, 16'd1));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h090, 16'd2,    16'd3,    0, 16'd2));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h191, 16'd3,    16'd4,    0, 16'd3));
        tbl.push_back(mk(1, 0, 16'd0,     1, 9'h191, 16'd3,    16'd4,    0, 16'd3));
        tbl.push_back(mk(1, 0, 16'd0,     1, 9'h191, 16'd3,    16'd4,    0, 16'd3));
        tbl.push_back(mk(1, 0, 16'd0,     1, 9'h191, 16'd3,    16'd4,    0, 16'd3));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h164, 16'd4,    16'd5,    0, 16'd4));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h0E0, 16'd5,    16'd6,    0, 16'd5));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h1A0, 16'd6,    16'd6,    1, 16'd6));
        tbl.push_back(mk(0, 0, 16'd0,     0, 9'h1A0, 16'd6,    16'd6,    1, 16'd6));
        tbl.push_back(mk(1, 0, 16'd0,     0, 9'h1A0, 16'd6,    16'd6,    1, 16'd6));
        // redirect out of HALTED to 3
        tbl.push_back(mk(0, 1, 16'd3,     0, 9'h1A0, 16'd6,    16'd3,    0, 16'd6));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h191, 16'd3,    16'd4,    0, 16'd7));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h164, 16'd4,    16'd5,    0, 16'd8));
        // redirect to 2 while if_pc=4
        tbl.push_back(mk(0, 1, 16'd2,     0, 9'h164, 16'd4,    16'd2,    0, 16'd8));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h090, 16'd2,    16'd3,    0, 16'd9));
        // stall + redirect together: redirect wins
        tbl.push_back(mk(1, 1, 16'd1,     0, 9'h090, 16'd2,    16'd1,    0, 16'd9));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h061, 16'd1,    16'd2,    0, 16'd10));
        // PC wrap through FFFF
        tbl.push_back(mk(0, 1, 16'hFFFF,  0, 9'h061, 16'd1,    16'hFFFF, 0, 16'd10));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h0F1, 16'hFFFF, 16'h0000, 0, 16'd11));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h0F2, 16'h0000, 16'h0001, 0, 16'd12));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h061, 16'h0001, 16'h0002, 0, 16'd13));
        // halt issued then stalled: valid held until stall drops
        tbl.push_back(mk(0, 1, 16'd5,     0, 9'h061, 16'd1,    16'd5,    0, 16'd13));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h0E0, 16'd5,    16'd6,    0, 16'd14));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h1A0, 16'd6,    16'd6,    1, 16'd15));
        tbl.push_back(mk(1, 0, 16'd0,     1, 9'h1A0, 16'd6,    16'd6,    1, 16'd15));
        tbl.push_back(mk(0, 0, 16'd0,     0, 9'h1A0, 16'd6,    16'd6,    1, 16'd15));
        // redirect while a halt is being fetched in RUN cancels it
        tbl.push_back(mk(0, 1, 16'd5,     0, 9'h1A0, 16'd6,    16'd5,    0, 16'd15));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h0E0, 16'd5,    16'd6,    0, 16'd16));
        tbl.push_back(mk(0, 1, 16'd2,     0, 9'h0E0, 16'd5,    16'd2,    0, 16'd16));
        tbl.push_back(mk(0, 0, 16'd0,     1, 9'h090, 16'd2,    16'd3,    0, 16'd17));

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'd0;
        step(1, 0, 0, 16'd0);
        step(1, 0, 0, 16'd0);
        check_reset("reset_state");

        foreach (tbl[i]) begin
            step(0, tbl[i].st, tbl[i].rv, tbl[i].rpc);
            check($sformatf("vec%0d", i), tbl[i].v, tbl[i].ins, tbl[i].ipc,
                  tbl[i].rom_pc, tbl[i].h, tbl[i].cnt);
        end

        // Reset mid-run at if_pc=4, with stall and redirect also asserted.
        step(1, 0, 0, 16'd0);
        check_reset("reset_again");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'd0);
        check("pre_reset_run", 1'b1, 9'h164, 16'd4, 16'd5, 1'b0, 16'd4);
        step(1, 1, 1, 16'd9);
        check_reset("reset_mid_run");

        // Reset while HALTED.
        for (int i = 0; i < 7; i++) step(0, 0, 0, 16'd0);
        check("pre_reset_halted", 1'b0, 9'h1A0, 16'd6, 16'd6, 1'b1, 16'd6);
        step(1, 0, 0, 16'd0);
        check_reset("reset_in_halted");
        step(0, 0, 0, 16'd0);
        check("post_reset_fetch", 1'b1, 9'h061, 16'd1, 16'd2, 1'b0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
